// File: rtl/rgb_pkg.sv
// Shared types and helpers for the RGB PWM driver.
// Contents: PWM_BITS width, rgb_t colour payload, FSM state encoding and the
// one-LSB step helper used by the fade engine.
package rgb_pkg;

  localparam int unsigned PWM_BITS = 8;

  // One colour command / duty triple.
  typedef struct packed {
    logic [PWM_BITS-1:0] r;
    logic [PWM_BITS-1:0] g;
    logic [PWM_BITS-1:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    FADING  = 2'd2
  } drv_state_t;

  // Move cur one LSB toward tgt; hold when equal.
  function automatic logic [PWM_BITS-1:0] step_toward(
    input logic [PWM_BITS-1:0] cur,
    input logic [PWM_BITS-1:0] tgt
  );
    if (cur < tgt) begin
      return cur + PWM_BITS'(1);
    end else if (cur > tgt) begin
      return cur - PWM_BITS'(1);
    end else begin
      return cur;
    end
  endfunction

endpackage

// File: rtl/rgb_pwm_channel.sv
// One PWM colour channel: duty register, optional fade target with +/-1
// stepping, and the registered pin compare.
// Build option: RGB_FADE_EN adds the target register and stepping.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   adopt         take adopt_val as the new value on this edge (a boundary)
//   adopt_val     new duty (no fade) or new target (fade)
//   step          fade step on this edge
//   pwm_cnt_nxt   value pwm_cnt takes on this edge
//   at_target_c   combinational: duty after this edge equals target after it
//   pin           registered PWM output, high while pwm_cnt < duty
module rgb_pwm_channel
  import rgb_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                adopt,
  input  logic [PWM_BITS-1:0] adopt_val,
  input  logic                step,
  input  logic [PWM_BITS-1:0] pwm_cnt_nxt,
  output logic                at_target_c,
  output logic                pin
);

  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] duty_nxt;

`ifdef RGB_FADE_EN
  logic [PWM_BITS-1:0] target;
  logic [PWM_BITS-1:0] target_nxt;

  // A retarget and a step on the same edge step toward the new target.
  always_comb begin
    target_nxt  = adopt ? adopt_val : target;
    duty_nxt    = step ? step_toward(duty, target_nxt) : duty;
    at_target_c = (duty_nxt == target_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target <= '0;
    end else begin
      target <= target_nxt;
    end
  end
`else
  logic unused_step;

  // Duty jumps straight to the adopted value.
  always_comb begin
    duty_nxt    = adopt ? adopt_val : duty;
    at_target_c = 1'b1;
  end

  assign unused_step = step;
`endif

  // Compare against next-cycle values so the registered pin lines up with
  // the cycle in which pwm_cnt and duty hold those values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty <= '0;
      pin  <= 1'b0;
    end else begin
      duty <= duty_nxt;
      pin  <= (pwm_cnt_nxt < duty_nxt);
    end
  end

endmodule

// File: rtl/rgb_pwm_driver.sv
// Command-driven RGB PWM driver. Captures colour commands on a valid/ready
// handshake into a pending register and applies them at PWM period
// boundaries so pin waveforms never show partial periods.
// Build option: RGB_FADE_EN enables the fade engine (FADING state, fade
// period counter, per-channel targets with +/-1 stepping).
// Ports:
//   clk, rst_n              clock, async active-low reset
//   cmd_valid / cmd_ready   command handshake
//   cmd_r, cmd_g, cmd_b     8-bit target duty per channel
//   RGB_R, RGB_G, RGB_B     active-high PWM pins (registered)
//   frame_start             pulse in the first cycle of each PWM period
//   busy                    command pending or fade in progress
module rgb_pwm_driver
  import rgb_pkg::*;
#(
  parameter int unsigned PRESCALE     = 47,
  parameter int unsigned FADE_PERIODS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_r,
  input  logic [7:0] cmd_g,
  input  logic [7:0] cmd_b,
  output logic       RGB_R,
  output logic       RGB_G,
  output logic       RGB_B,
  output logic       frame_start,
  output logic       busy
);

  localparam int unsigned PS_W = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;

  logic [PS_W-1:0]     prescale_cnt;
  logic [PS_W-1:0]     prescale_nxt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] pwm_cnt_nxt;
  logic                tick_c;
  logic                boundary_c;

  rgb_t                pending_q;
  logic                pending_full;
  logic                pending_full_nxt;
  logic                hs_c;
  logic                adopt_c;
  logic                step_c;
  logic [2:0]          chan_at_c;

  drv_state_t          state;

  // Prescaler and PWM counter; the boundary is the tick wrapping 255 -> 0.
  always_comb begin
    tick_c       = (prescale_cnt == PS_W'(PRESCALE));
    prescale_nxt = tick_c ? '0 : prescale_cnt + PS_W'(1);
    pwm_cnt_nxt  = tick_c ? pwm_cnt + PWM_BITS'(1) : pwm_cnt;
    boundary_c   = tick_c && (pwm_cnt == {PWM_BITS{1'b1}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale_cnt <= '0;
      pwm_cnt      <= '0;
      frame_start  <= 1'b0;
    end else begin
      prescale_cnt <= prescale_nxt;
      pwm_cnt      <= pwm_cnt_nxt;
      frame_start  <= boundary_c;
    end
  end

  // Handshake and pending register. A capture on a boundary edge is never
  // adopted on that edge because adoption needs pending_full already set.
  always_comb begin
    hs_c             = cmd_valid && cmd_ready;
    adopt_c          = boundary_c && pending_full;
    pending_full_nxt = hs_c || (pending_full && !adopt_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q    <= '0;
      pending_full <= 1'b0;
      cmd_ready    <= 1'b0;
    end else begin
      if (hs_c) begin
        pending_q <= rgb_t'({cmd_r, cmd_g, cmd_b});
      end
      pending_full <= pending_full_nxt;
      cmd_ready    <= !pending_full_nxt;
    end
  end

`ifdef RGB_FADE_EN
  localparam int unsigned FC_W = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;

  logic [FC_W-1:0] fade_cnt;
  logic            all_at_c;

  always_comb begin
    all_at_c = &chan_at_c;
    step_c   = (state == FADING) && boundary_c &&
               (fade_cnt == FC_W'(FADE_PERIODS - 1));
  end
`else
  logic [31:0] unused_fade_periods;
  logic        unused_chan_at;

  assign step_c              = 1'b0;
  assign unused_fade_periods = 32'(FADE_PERIODS);
  assign unused_chan_at      = ^chan_at_c;
`endif

  // Control FSM; busy mirrors pending_full plus the FADING state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
`ifdef RGB_FADE_EN
      fade_cnt <= '0;
`endif
    end else begin
      busy <= pending_full_nxt;
      case (state)
        IDLE, PENDING: begin
          if (adopt_c) begin
`ifdef RGB_FADE_EN
            fade_cnt <= '0;
            if (all_at_c) begin
              state <= IDLE;
            end else begin
              state <= FADING;
              busy  <= 1'b1;
            end
`else
            state <= IDLE;
`endif
          end else if (pending_full_nxt) begin
            state <= PENDING;
          end
        end
`ifdef RGB_FADE_EN
        FADING: begin
          busy <= 1'b1;
          if (boundary_c) begin
            fade_cnt <= step_c ? '0 : fade_cnt + FC_W'(1);
            if (all_at_c) begin
              state <= IDLE;
              busy  <= pending_full_nxt;
            end
          end
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  rgb_pwm_channel u_chan_r (
    .clk         (clk),
    .rst_n       (rst_n),
    .adopt       (adopt_c),
    .adopt_val   (pending_q.r),
    .step        (step_c),
    .pwm_cnt_nxt (pwm_cnt_nxt),
    .at_target_c (chan_at_c[2]),
    .pin         (RGB_R)
  );

  rgb_pwm_channel u_chan_g (
    .clk         (clk),
    .rst_n       (rst_n),
    .adopt       (adopt_c),
    .adopt_val   (pending_q.g),
    .step        (step_c),
    .pwm_cnt_nxt (pwm_cnt_nxt),
    .at_target_c (chan_at_c[1]),
    .pin         (RGB_G)
  );

  rgb_pwm_channel u_chan_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .adopt       (adopt_c),
    .adopt_val   (pending_q.b),
    .step        (step_c),
    .pwm_cnt_nxt (pwm_cnt_nxt),
    .at_target_c (chan_at_c[0]),
    .pin         (RGB_B)
  );

endmodule
